// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        KILL
    } fetch_state_e;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_buffer.sv
// Registered {pc, instruction, valid} triple presented to decode.
// Priority: flush > load > freeze; with no control asserted the slot empties.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        freeze,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out     <= 32'h0;
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (flush) begin
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (load) begin
            pc_out     <= load_pc;
            inst_out   <= load_inst;
            inst_valid <= 1'b1;
        end else if (!freeze) begin
            // Decode consumed the instruction this cycle; present a NOP from now on.
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, one-at-a-time memory request FSM
// and the decode-facing output buffer.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mul_stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        if_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic         buf_load, buf_freeze, buf_flush;
    logic         hold;
    logic [31:0]  target;
    logic [31:0]  pc_next_seq;

    assign hold        = stall | mul_stall;
    assign target      = jb_target & PC_ALIGN_MASK;
    assign pc_next_seq = pc_q + 32'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_load    = 1'b0;
        buf_flush   = 1'b0;
        buf_freeze  = hold;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (jb) pc_d = target;
            end
            FETCH: begin
                if (jb) begin
                    buf_flush = 1'b1;
                    pc_d      = target;
                    if (!im_rvalid) begin
                        // The old request is still in flight; its address must stay stable.
                        kill_addr_d = pc_q;
                        state_d     = KILL;
                    end
                end else if (im_rvalid) begin
                    buf_load = 1'b1;
                    if (hold) state_d = HOLD;
                    else      pc_d    = pc_next_seq;
                end
            end
            HOLD: begin
                if (jb) begin
                    buf_flush = 1'b1;
                    pc_d      = target;
                    state_d   = FETCH;
                end else if (!hold) begin
                    pc_d    = pc_next_seq;
                    state_d = FETCH;
                end
            end
            KILL: begin
                if (jb) begin
                    buf_flush = 1'b1;
                    pc_d      = target;
                end
                if (im_rvalid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign im_req  = (state_q == FETCH) || (state_q == KILL);
    assign im_addr = (state_q == KILL) ? kill_addr_q : pc_q;
    assign if_busy = im_req & ~im_rvalid;

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .freeze     (buf_freeze),
        .flush      (buf_flush),
        .load_pc    (pc_q),
        .load_inst  (im_rdata),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .inst_valid (inst_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; a second instance with RESET_PC near the
// top of the address space shares the stimulus to exercise PC wrap-around.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, mul_stall, jb, im_rvalid;
    logic [31:0] jb_target, im_rdata;

    logic        im_req_a, inst_valid_a, if_busy_a;
    logic [31:0] im_addr_a, pc_out_a, inst_out_a;
    logic        im_req_b, inst_valid_b, if_busy_b;
    logic [31:0] im_addr_b, pc_out_b, inst_out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .mul_stall(mul_stall),
        .jb(jb), .jb_target(jb_target),
        .im_req(im_req_a), .im_addr(im_addr_a),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .pc_out(pc_out_a), .inst_out(inst_out_a),
        .inst_valid(inst_valid_a), .if_busy(if_busy_a)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .mul_stall(mul_stall),
        .jb(jb), .jb_target(jb_target),
        .im_req(im_req_b), .im_addr(im_addr_b),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .pc_out(pc_out_b), .inst_out(inst_out_b),
        .inst_valid(inst_valid_b), .if_busy(if_busy_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle with no response, then the response cycle.
    task automatic fetch_seq(input logic [31:0] data, input logic [31:0] addr, input logic [31:0] next_addr);
        im_rvalid = 1'b0;
        tick();
        check("req_addr", im_addr_a, addr);
        check("req_busy", if_busy_a, 1);
        check("req_valid", inst_valid_a, 0);
        im_rvalid = 1'b1;
        im_rdata  = data;
        tick();
        check("rsp_inst", inst_out_a, data);
        check("rsp_pc", pc_out_a, addr);
        check("rsp_valid", inst_valid_a, 1);
        check("rsp_next_addr", im_addr_a, next_addr);
        im_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; mul_stall = 1'b0; jb = 1'b0;
        jb_target = 32'h0; im_rvalid = 1'b0; im_rdata = 32'h0;
        tick();
        tick();
        check("rst_req", im_req_a, 0);
        check("rst_addr", im_addr_a, 32'h0);
        check("rst_addr_b", im_addr_b, 32'hFFFF_FFFC);
        check("rst_valid", inst_valid_a, 0);
        check("rst_inst", inst_out_a, 32'h0);
        check("rst_pc", pc_out_a, 32'h0);
        check("rst_busy", if_busy_a, 0);
        rst = 1'b0;

        // Sequential fetches; instance b wraps from FFFF_FFFC to 0.
        fetch_seq(32'h0010_0093, 32'h0, 32'h4);
        check("wrap_addr_b", im_addr_b, 32'h0000_0000);
        check("wrap_pc_b", pc_out_b, 32'hFFFF_FFFC);
        fetch_seq(32'h0020_0113, 32'h4, 32'h8);
        check("seq_addr_b", im_addr_b, 32'h0000_0004);

        // Response at 0x8 under stall: hold for three cycles.
        tick();
        check("s_addr8", im_addr_a, 32'h8);
        im_rvalid = 1'b1; im_rdata = 32'h0030_0193; stall = 1'b1;
        tick();
        check("s_valid1", inst_valid_a, 1);
        check("s_inst1", inst_out_a, 32'h0030_0193);
        check("s_pc1", pc_out_a, 32'h8);
        check("s_req1", im_req_a, 0);
        im_rvalid = 1'b0; stall = 1'b0; mul_stall = 1'b1;
        tick();
        check("s_inst2", inst_out_a, 32'h0030_0193);
        check("s_req2", im_req_a, 0);
        stall = 1'b1; mul_stall = 1'b0;
        tick();
        check("s_inst3", inst_out_a, 32'h0030_0193);
        check("s_pc3", pc_out_a, 32'h8);
        check("s_valid3", inst_valid_a, 1);
        stall = 1'b0;
        tick();
        check("s_release_req", im_req_a, 1);
        check("s_release_addr", im_addr_a, 32'hC);
        check("s_release_valid", inst_valid_a, 0);

        // Load at 0xC, then stall in FETCH freezes the presented instruction.
        im_rvalid = 1'b1; im_rdata = 32'h0040_0213;
        tick();
        check("c_inst", inst_out_a, 32'h0040_0213);
        check("c_pc", pc_out_a, 32'hC);
        check("c_next", im_addr_a, 32'h10);
        im_rvalid = 1'b0; stall = 1'b1;
        tick();
        check("f_valid", inst_valid_a, 1);
        check("f_inst", inst_out_a, 32'h0040_0213);
        check("f_req", im_req_a, 1);
        stall = 1'b0;
        tick();
        check("f_clear_valid", inst_valid_a, 0);
        check("f_clear_inst", inst_out_a, 32'h0);

        // Redirect while request to 0x10 is outstanding.
        jb = 1'b1; jb_target = 32'h0000_0103;
        tick();
        check("k_req", im_req_a, 1);
        check("k_addr", im_addr_a, 32'h10);
        check("k_busy", if_busy_a, 1);
        jb = 1'b0;
        tick();
        check("k_addr2", im_addr_a, 32'h10);
        check("k_busy2", if_busy_a, 1);
        im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF;
        tick();
        check("k_drop_valid", inst_valid_a, 0);
        check("k_drop_inst", inst_out_a, 32'h0);
        check("k_target", im_addr_a, 32'h100);
        check("k_target_req", im_req_a, 1);
        im_rvalid = 1'b0;

        // jb together with rvalid and stall: jb wins.
        fetch_seq(32'h0050_0293, 32'h100, 32'h104);
        im_rvalid = 1'b1; im_rdata = 32'h0060_0313; jb = 1'b1;
        jb_target = 32'h0000_0201; stall = 1'b1;
        tick();
        check("jr_valid", inst_valid_a, 0);
        check("jr_inst", inst_out_a, 32'h0);
        check("jr_addr", im_addr_a, 32'h200);
        check("jr_req", im_req_a, 1);
        im_rvalid = 1'b0; jb = 1'b0; stall = 1'b0;

        // jb in HOLD overrides stall.
        tick();
        im_rvalid = 1'b1; im_rdata = 32'h0070_0393; stall = 1'b1;
        tick();
        check("hj_hold_valid", inst_valid_a, 1);
        check("hj_hold_req", im_req_a, 0);
        im_rvalid = 1'b0; jb = 1'b1; jb_target = 32'h0000_0300;
        tick();
        check("hj_valid", inst_valid_a, 0);
        check("hj_req", im_req_a, 1);
        check("hj_addr", im_addr_a, 32'h300);
        jb = 1'b0; stall = 1'b0;

        // Asynchronous reset mid-FETCH with stall high.
        im_rvalid = 1'b1; im_rdata = 32'h0080_0413;
        tick();
        check("ar_pre_valid", inst_valid_a, 1);
        check("ar_pre_pc", pc_out_a, 32'h300);
        im_rvalid = 1'b0; stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        check("ar_req", im_req_a, 0);
        check("ar_addr", im_addr_a, 32'h0);
        check("ar_valid", inst_valid_a, 0);
        check("ar_inst", inst_out_a, 32'h0);
        check("ar_pc", pc_out_a, 32'h0);
        check("ar_busy", if_busy_a, 0);
        #1 rst = 1'b0; stall = 1'b0;
        tick();
        check("ar_restart_req", im_req_a, 1);
        check("ar_restart_addr", im_addr_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
